// File: rtl/snn_soc_pkg.sv
// Shared SoC constants and types; this slice holds the WL pin-multiplex receiver additions.
package snn_soc_pkg;

    localparam int NUM_INPUTS     = 64;
    localparam int WL_GROUP_WIDTH = 8;
    localparam int WL_RX_TIMEOUT  = 16;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ORDER   = 2'd1,
        ERR_TIMEOUT = 2'd2
    } wl_rx_err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } wl_rx_state_e;

endpackage

// File: rtl/wl_demux_receiver.sv
// Far end of the WL pin-multiplex link: reassembles ascending groups into one WL bitmap,
// pulses valid per complete frame and flags order/timeout errors.
module wl_demux_receiver
    import snn_soc_pkg::*;
#(
    parameter int P_NUM_INPUTS  = NUM_INPUTS,
    parameter int P_GROUP_W     = WL_GROUP_WIDTH,
    parameter int P_TIMEOUT_CYC = WL_RX_TIMEOUT,
    localparam int GROUPS = P_NUM_INPUTS / P_GROUP_W,
    localparam int SEL_W  = $clog2(GROUPS),
    localparam int TO_W   = $clog2(P_TIMEOUT_CYC + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [P_GROUP_W-1:0]    wl_data,
    input  logic [SEL_W-1:0]        wl_group_sel,
    input  logic                    wl_latch,
    output logic [P_NUM_INPUTS-1:0] wl_bitmap_out,
    output logic                    wl_valid_pulse_out,
    output logic                    rx_busy,
    output logic                    err_pulse,
    output logic [1:0]              err_code,
    output logic [7:0]              err_cnt,
    input  logic                    err_clr
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(GROUPS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(P_TIMEOUT_CYC - 1);

    wl_rx_state_e            state_q, state_d;
    logic [SEL_W-1:0]        exp_q, exp_d;
    logic [TO_W-1:0]         timer_q, timer_d;
    logic [P_NUM_INPUTS-1:0] shadow_q, shadow_d;
    logic [P_NUM_INPUTS-1:0] bitmap_d;
    logic                    valid_d;
    wl_rx_err_e              err;
    logic                    errp_d;
    wl_rx_err_e              code_q, code_d;
    logic [7:0]              cnt_d;

    assign rx_busy  = (state_q == ST_RECV);
    assign err_code = code_q;

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        timer_d  = timer_q;
        shadow_d = shadow_q;
        bitmap_d = wl_bitmap_out;
        valid_d  = 1'b0;
        err      = ERR_NONE;

        if (state_q == ST_DONE) begin
            bitmap_d = shadow_q;
            valid_d  = 1'b1;
            exp_d    = '0;
            state_d  = ST_IDLE;
        end

        // ST_DONE falls through to idle rules so a new frame may start back-to-back.
        if (state_q != ST_RECV) begin
            if (wl_latch) begin
                if (wl_group_sel == '0) begin
                    shadow_d[0 +: P_GROUP_W] = wl_data;
                    exp_d   = SEL_W'(1);
                    timer_d = '0;
                    state_d = ST_RECV;
                end else begin
                    err     = ERR_ORDER;
                    state_d = ST_IDLE;
                end
            end
        end else if (wl_latch) begin
            timer_d = '0;
            if (wl_group_sel == exp_q) begin
                shadow_d[int'(exp_q) * P_GROUP_W +: P_GROUP_W] = wl_data;
                if (exp_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    exp_d = exp_q + 1'b1;
                end
            end else if (wl_group_sel == '0) begin
                err = ERR_ORDER;
                shadow_d[0 +: P_GROUP_W] = wl_data;
                exp_d = SEL_W'(1);
            end else begin
                err     = ERR_ORDER;
                exp_d   = '0;
                state_d = ST_IDLE;
            end
        end else if (timer_q == TO_LAST) begin
            err     = ERR_TIMEOUT;
            exp_d   = '0;
            timer_d = '0;
            state_d = ST_IDLE;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // A new error wins over a same-cycle clear: count restarts at 1.
    always_comb begin
        errp_d = (err != ERR_NONE);
        code_d = code_q;
        cnt_d  = err_cnt;
        if (err != ERR_NONE) begin
            code_d = err;
            if (err_clr) begin
                cnt_d = 8'd1;
            end else if (err_cnt != 8'hFF) begin
                cnt_d = err_cnt + 8'd1;
            end
        end else if (err_clr) begin
            code_d = ERR_NONE;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            exp_q              <= '0;
            timer_q            <= '0;
            shadow_q           <= '0;
            wl_bitmap_out      <= '0;
            wl_valid_pulse_out <= 1'b0;
            err_pulse          <= 1'b0;
            code_q             <= ERR_NONE;
            err_cnt            <= '0;
        end else begin
            state_q            <= state_d;
            exp_q              <= exp_d;
            timer_q            <= timer_d;
            shadow_q           <= shadow_d;
            wl_bitmap_out      <= bitmap_d;
            wl_valid_pulse_out <= valid_d;
            err_pulse          <= errp_d;
            code_q             <= code_d;
            err_cnt            <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    if (P_NUM_INPUTS % P_GROUP_W != 0) begin : g_chk_width
        $fatal(1, "wl_demux_receiver: P_NUM_INPUTS not a multiple of P_GROUP_W");
    end
    if (P_TIMEOUT_CYC < 2) begin : g_chk_timeout
        $fatal(1, "wl_demux_receiver: P_TIMEOUT_CYC must be at least 2");
    end

    always_ff @(posedge clk) begin
        if (err_pulse) begin
            $warning("wl_demux_receiver: rx error event, code %0d", err_code);
        end
    end
`endif

endmodule

// File: tb/tb_wl_demux_receiver.sv
// Directed bench for wl_demux_receiver: full frames, gaps, order/timeout errors, clear and reset.
module tb_wl_demux_receiver;
    import snn_soc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  wl_data;
    logic [2:0]  wl_group_sel;
    logic        wl_latch;
    logic [63:0] wl_bitmap_out;
    logic        wl_valid_pulse_out;
    logic        rx_busy;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;
    logic        err_clr;

    int unsigned n_cmp    = 0;
    int unsigned n_err    = 0;
    int unsigned pulse_cnt = 0;
    int unsigned errp_cnt  = 0;

    logic [63:0] b1 = 64'hDEAD_BEEF_0123_4567;
    logic [63:0] b3 = 64'h1111_2222_3333_4444;
    logic [63:0] bx = 64'h5555_6666_7777_8888;
    logic [63:0] b4 = 64'h0F1E_2D3C_4B5A_6978;
    logic [63:0] b5 = 64'hCAFE_F00D_1234_5678;
    logic [63:0] b6 = 64'h0123_4567_89AB_CDEF;

    wl_demux_receiver #(
        .P_NUM_INPUTS (64),
        .P_GROUP_W    (8),
        .P_TIMEOUT_CYC(16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wl_data           (wl_data),
        .wl_group_sel      (wl_group_sel),
        .wl_latch          (wl_latch),
        .wl_bitmap_out     (wl_bitmap_out),
        .wl_valid_pulse_out(wl_valid_pulse_out),
        .rx_busy           (rx_busy),
        .err_pulse         (err_pulse),
        .err_code          (err_code),
        .err_cnt           (err_cnt),
        .err_clr           (err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wl_valid_pulse_out === 1'b1) pulse_cnt++;
        if (err_pulse === 1'b1) errp_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic l, input logic [2:0] s, input logic [7:0] d, input logic c);
        @(negedge clk);
        wl_latch     = l;
        wl_group_sel = s;
        wl_data      = d;
        err_clr      = c;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input logic [63:0] bm, input int unsigned gap);
        for (int unsigned g = 0; g < 8; g++) begin
            step(1'b1, g[2:0], bm[g*8 +: 8], 1'b0);
            if (g < 7) repeat (gap) idle();
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        wl_latch     = 1'b0;
        wl_group_sel = '0;
        wl_data      = '0;
        err_clr      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bitmap", wl_bitmap_out, 64'h0);
        chk("rst_valid", 64'(wl_valid_pulse_out), 64'h0);
        chk("rst_busy", 64'(rx_busy), 64'h0);
        chk("rst_errp", 64'(err_pulse), 64'h0);
        chk("rst_code", 64'(err_code), 64'h0);
        chk("rst_cnt", 64'(err_cnt), 64'h0);
        rst_n = 1'b1;
        idle();

        // T1: back-to-back groups, pulse two cycles after the last latch
        send_frame(b1, 0);
        idle();
        chk("t1_valid_early", 64'(wl_valid_pulse_out), 64'h0);
        chk("t1_bitmap_early", wl_bitmap_out, 64'h0);
        idle();
        chk("t1_valid", 64'(wl_valid_pulse_out), 64'h1);
        chk("t1_bitmap", wl_bitmap_out, b1);
        chk("t1_errcnt", 64'(err_cnt), 64'h0);
        chk("t1_busy", 64'(rx_busy), 64'h0);
        idle();
        chk("t1_valid_end", 64'(wl_valid_pulse_out), 64'h0);
        chk("t1_pulses", 64'(pulse_cnt), 64'd1);

        // T2: gapped frame, then a zero frame starting in the done cycle
        send_frame(b1, 3);
        step(1'b1, 3'd0, 8'h00, 1'b0);
        chk("t2_valid_done", 64'(wl_valid_pulse_out), 64'h0);
        step(1'b1, 3'd1, 8'h00, 1'b0);
        chk("t2_valid1", 64'(wl_valid_pulse_out), 64'h1);
        chk("t2_bitmap1", wl_bitmap_out, b1);
        chk("t2_busy_b2b", 64'(rx_busy), 64'h1);
        for (int unsigned g = 2; g < 8; g++) step(1'b1, g[2:0], 8'h00, 1'b0);
        idle();
        idle();
        chk("t2_valid2", 64'(wl_valid_pulse_out), 64'h1);
        chk("t2_bitmap2", wl_bitmap_out, 64'h0);
        idle();
        chk("t2_pulses", 64'(pulse_cnt), 64'd3);
        chk("t2_errcnt", 64'(err_cnt), 64'h0);

        // T3: skip from group 2 to group 5
        step(1'b1, 3'd0, b3[7:0], 1'b0);
        step(1'b1, 3'd1, b3[15:8], 1'b0);
        chk("t3_busy_mid", 64'(rx_busy), 64'h1);
        step(1'b1, 3'd2, b3[23:16], 1'b0);
        step(1'b1, 3'd5, b3[47:40], 1'b0);
        idle();
        chk("t3_errp", 64'(err_pulse), 64'h1);
        chk("t3_code", 64'(err_code), 64'(ERR_ORDER));
        chk("t3_cnt", 64'(err_cnt), 64'h1);
        chk("t3_busy", 64'(rx_busy), 64'h0);
        idle();
        chk("t3_errp_end", 64'(err_pulse), 64'h0);
        chk("t3_bitmap", wl_bitmap_out, 64'h0);
        chk("t3_pulses", 64'(pulse_cnt), 64'd3);

        // plain clear
        step(1'b0, 3'd0, 8'h00, 1'b1);
        idle();
        chk("clr_code", 64'(err_code), 64'h0);
        chk("clr_cnt", 64'(err_cnt), 64'h0);

        // T4: restart with group 0 mid-frame
        for (int unsigned g = 0; g < 4; g++) step(1'b1, g[2:0], bx[g*8 +: 8], 1'b0);
        step(1'b1, 3'd0, b4[7:0], 1'b0);
        for (int unsigned g = 1; g < 8; g++) begin
            step(1'b1, g[2:0], b4[g*8 +: 8], 1'b0);
            if (g == 1) begin
                chk("t4_errp", 64'(err_pulse), 64'h1);
                chk("t4_code", 64'(err_code), 64'(ERR_ORDER));
                chk("t4_busy", 64'(rx_busy), 64'h1);
            end
        end
        idle();
        idle();
        chk("t4_valid", 64'(wl_valid_pulse_out), 64'h1);
        chk("t4_bitmap", wl_bitmap_out, b4);
        chk("t4_cnt", 64'(err_cnt), 64'h1);
        idle();
        chk("t4_errps", 64'(errp_cnt), 64'd2);

        // T5: 15 idle cycles tolerated, the 16th times out
        for (int unsigned g = 0; g < 3; g++) step(1'b1, g[2:0], 8'hA5, 1'b0);
        repeat (16) idle();
        chk("t5_no_to_yet", 64'(err_pulse), 64'h0);
        chk("t5_busy_wait", 64'(rx_busy), 64'h1);
        idle();
        chk("t5_errp", 64'(err_pulse), 64'h1);
        chk("t5_code", 64'(err_code), 64'(ERR_TIMEOUT));
        chk("t5_cnt", 64'(err_cnt), 64'h2);
        chk("t5_busy", 64'(rx_busy), 64'h0);
        send_frame(b5, 0);
        idle();
        idle();
        chk("t5_valid", 64'(wl_valid_pulse_out), 64'h1);
        chk("t5_bitmap", wl_bitmap_out, b5);
        chk("t5_cnt_keep", 64'(err_cnt), 64'h2);
        step(1'b1, 3'd3, 8'h00, 1'b1);
        idle();
        chk("t5_clr_errp", 64'(err_pulse), 64'h1);
        chk("t5_clr_code", 64'(err_code), 64'(ERR_ORDER));
        chk("t5_clr_cnt", 64'(err_cnt), 64'h1);

        // T6: reset in the middle of a frame
        for (int unsigned g = 0; g < 5; g++) step(1'b1, g[2:0], 8'h3C, 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        wl_latch = 1'b0;
        #1;
        chk("t6_rst_bitmap", wl_bitmap_out, 64'h0);
        chk("t6_rst_busy", 64'(rx_busy), 64'h0);
        chk("t6_rst_code", 64'(err_code), 64'h0);
        chk("t6_rst_cnt", 64'(err_cnt), 64'h0);
        chk("t6_rst_errp", 64'(err_pulse), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
        chk("t6_no_pulse", 64'(pulse_cnt), 64'd5);
        chk("t6_no_err", 64'(errp_cnt), 64'd4);
        send_frame(b6, 0);
        idle();
        idle();
        chk("t6_valid", 64'(wl_valid_pulse_out), 64'h1);
        chk("t6_bitmap", wl_bitmap_out, b6);
        chk("t6_cnt", 64'(err_cnt), 64'h0);
        idle();
        chk("t6_pulses", 64'(pulse_cnt), 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
